prga_decrypt: RTL and testbench

//  ARC4 PRGA + decrypt stage. Sits directly downstream of the init/KSA stage

---
 rtl/prga_decrypt.sv | 150 +++++++++++++++
 tb/tb_prga_decrypt.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt.sv
// ARC4 keystream + decrypt: reads length-prefixed ct, swaps S, writes length-prefixed pt.
// Latency 2+6*len cycles from en acceptance to rdy; no backpressure, memories must answer in one cycle.
module prga_decrypt #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          rdy,
    output logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_rddata,
    output logic [DW-1:0] s_wrdata,
    output logic          s_wren,
    output logic [AW-1:0] ct_addr,
    input  logic [DW-1:0] ct_rddata,
    output logic [AW-1:0] pt_addr,
    output logic [DW-1:0] pt_wrdata,
    output logic          pt_wren
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LEN_RD = 4'd1;
    localparam logic [3:0] ST_LEN_LD = 4'd2;
    localparam logic [3:0] ST_SI_RD  = 4'd3;
    localparam logic [3:0] ST_SI_LD  = 4'd4;
    localparam logic [3:0] ST_SJ_LD  = 4'd5;
    localparam logic [3:0] ST_SI_WR  = 4'd6;
    localparam logic [3:0] ST_PAD_RD = 4'd7;
    localparam logic [3:0] ST_PAD_LD = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] k_q, k_d;
    logic [DW-1:0] len_q, len_d;
    logic [DW-1:0] si_q, si_d;
    logic [DW-1:0] sj_q, sj_d;
    logic [DW-1:0] pad_idx;

    assign pad_idx = si_q + sj_q;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = ST_LEN_RD;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_LEN_RD: begin
                ct_addr = '0;
                state_d = ST_LEN_LD;
            end
            ST_LEN_LD: begin
                len_d     = ct_rddata;
                pt_addr   = '0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                if (ct_rddata == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = AW'(1);
                    i_d     = AW'(1);
                    state_d = ST_SI_RD;
                end
            end
            ST_SI_RD: begin
                s_addr  = i_q;
                state_d = ST_SI_LD;
            end
            ST_SI_LD: begin
                si_d    = s_rddata;
                j_d     = j_q + AW'(s_rddata);
                s_addr  = j_q + AW'(s_rddata);
                state_d = ST_SJ_LD;
            end
            ST_SJ_LD: begin
                // j_q already holds the updated j; store S[i] there first
                sj_d     = s_rddata;
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = ST_SI_WR;
            end
            ST_SI_WR: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
                state_d  = ST_PAD_RD;
            end
            ST_PAD_RD: begin
                s_addr  = AW'(pad_idx);
                ct_addr = k_q;
                state_d = ST_PAD_LD;
            end
            ST_PAD_LD: begin
                pt_addr   = k_q;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k_q == AW'(len_q)) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k_q + AW'(1);
                    i_d     = i_q + AW'(1);
                    state_d = ST_SI_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: one-cycle-latency memory models plus a plain ARC4 PRGA reference.
module tb_prga_decrypt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;

    int total = 0;
    int bad   = 0;

    logic [7:0]  s_mem  [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  pt_mem [256];
    logic [7:0]  exp_s  [256];
    logic [7:0]  exp_pt [256];
    logic [15:0] pt_log [$];
    int          s_wr_cnt  = 0;
    int          x_err     = 0;
    int          multi_err = 0;

    always #5 clk = ~clk;

    prga_decrypt #(.DW(8), .AW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (s_wren) begin
            s_mem[s_addr] = s_wrdata;
            s_wr_cnt++;
        end
        if (pt_wren && !rst) begin
            pt_mem[pt_addr] = pt_wrdata;
            pt_log.push_back({pt_addr, pt_wrdata});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ($isunknown({rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren}))
                x_err++;
            if (s_wren && pt_wren)
                multi_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_identity();
        for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
    endtask

    task automatic load_shuffled();
        logic [7:0] t;
        int r;
        load_identity();
        for (int n = 255; n > 0; n--) begin
            r = $urandom_range(n, 0);
            t = s_mem[n]; s_mem[n] = s_mem[r]; s_mem[r] = t;
        end
    endtask

    // Textbook ARC4 PRGA over a copy of the current S contents.
    task automatic run_model(input int len);
        int i, j;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) exp_s[n] = s_mem[n];
        exp_pt[0] = 8'(len);
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(exp_s[i])) % 256;
            t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
            exp_pt[n] = ct_mem[n] ^ exp_s[(int'(exp_s[i]) + int'(exp_s[j])) % 256];
        end
    endtask

    // Pulse en, then count cycles until rdy returns; a busy-time en pulse must be ignored.
    task automatic start_and_wait(input string tag, input int exp_lat);
        int n;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        chk({tag, "_rdy_fall"}, 32'(rdy), 32'd0);
        n = 0;
        while (!rdy && n < exp_lat + 50) begin
            @(negedge clk);
            n++;
            if (n == 1 && exp_lat > 4) en = 1'b1;
            if (n == 2) en = 1'b0;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic do_test(input string tag, input int len);
        int base, mism;
        run_model(len);
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'hxx;
        base = pt_log.size();
        start_and_wait(tag, 2 + 6 * len);
        repeat (2) @(negedge clk);
        chk({tag, "_pt_writes"}, 32'(pt_log.size() - base), 32'(len + 1));
        mism = 0;
        for (int n = 0; n <= len; n++) if (pt_mem[n] !== exp_pt[n]) mism++;
        chk({tag, "_pt_mismatches"}, 32'(mism), 32'd0);
        mism = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) mism++;
        chk({tag, "_s_mismatches"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int base, mism, wr0, n, len;
        load_identity();
        for (int m = 0; m < 256; m++) ct_mem[m] = 8'h00;
        #1;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_wren", {30'd0, s_wren, pt_wren}, 32'd0);
        chk("rst_addr", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // empty message
        ct_mem[0] = 8'h00;
        wr0 = s_wr_cnt;
        do_test("t1", 0);
        chk("t1_pt0", 32'(pt_mem[0]), 32'h00);
        chk("t1_no_s_write", 32'(s_wr_cnt - wr0), 32'd0);

        // zeros reveal the raw keystream
        load_identity();
        ct_mem[0] = 8'h03; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00; ct_mem[3] = 8'h00;
        do_test("t2", 3);
        chk("t2_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
        chk("t2_s", {8'd0, s_mem[2], s_mem[3], s_mem[5]}, 32'h00030502);

        load_identity();
        ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
        do_test("t3", 3);
        chk("t3_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03434744);

        // full-length message; j wraps many times
        load_identity();
        ct_mem[0] = 8'hFF;
        for (int m = 1; m < 256; m++) ct_mem[m] = 8'($urandom);
        do_test("t4", 255);

        // randomized permutations and lengths
        for (int r = 0; r < 4; r++) begin
            load_shuffled();
            len = $urandom_range(40, 1);
            ct_mem[0] = 8'(len);
            for (int m = 1; m <= len; m++) ct_mem[m] = 8'($urandom);
            do_test("rand", len);
        end

        // reset in the middle of the second byte
        load_identity();
        ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
        repeat (10) @(negedge clk);
        base = pt_log.size();
        rst = 1'b1;
        #1;
        chk("t5_rst_rdy", 32'(rdy), 32'd1);
        chk("t5_rst_wren", {30'd0, s_wren, pt_wren}, 32'd0);
        chk("t5_rst_addr", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_writes_after_rst", 32'(pt_log.size() - base), 32'd0);
        load_identity();
        do_test("t5", 3);
        chk("t5_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03434744);

        // en held high: back-to-back runs, S restored between them
        load_identity();
        run_model(3);
        base = pt_log.size();
        @(negedge clk) en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("t6_rdy_fall", 32'(rdy), 32'd0);
            n = 0;
            while (!rdy && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_latency", 32'(n), 32'd20);
            load_identity();
            if (r == 2) en = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("t6_pt_writes", 32'(pt_log.size() - base), 32'd12);
        mism = 0;
        for (int m = 0; m < 12 && base + m < pt_log.size(); m++)
            if (pt_log[base + m] !== {8'(m % 4), exp_pt[m % 4]}) mism++;
        chk("t6_pt_mismatches", 32'(mism), 32'd0);

        chk("no_x_outputs", 32'(x_err), 32'd0);
        chk("single_wren", 32'(multi_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
